// File: rtl/swervolf_ddr_gate.sv
// AXI4 gate in front of the LiteDRAM controller: stalls traffic until calibration
// finishes, forwards in-window transactions and answers everything else locally with an error.
`timescale 1ns/1ps
module swervolf_ddr_gate #(
  parameter int ID_WIDTH        = 6,
  parameter int DATA_WIDTH      = 64,
  parameter int MEM_ADDR_BITS   = 27,
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_init_done,
  input  logic                    i_init_error,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [31:0]             s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [31:0]             s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [31:0]             m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [31:0]             m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic                    o_err_wr,
  output logic                    o_err_rd
);
  localparam int CW = 4;

  typedef enum logic [1:0] {W_IDLE, W_SINK, W_RESP} wst_t;
  typedef enum logic       {R_IDLE, R_RESP} rst_t;

  logic          ready_q, ready_d, fail_q, fail_d;
  wst_t          ws_q, ws_d;
  rst_t          rs_q, rs_d;
  logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [ID_WIDTH-1:0] wid_q, wid_d, rid_q, rid_d;
  logic [7:0]    beats_q, beats_d;
  logic          err_wr_q, err_wr_d, err_rd_q, err_rd_d;

  logic en, aw_err, ar_err, aw_fwd_ok, ar_fwd_ok, aw_err_ok, ar_err_ok;
  logic w_pass, b_hs, r_last_hs, aw_fwd_hs, ar_fwd_hs;
  logic [1:0] err_resp;

  assign en        = ready_q | fail_q;
  assign err_resp  = fail_q ? 2'b10 : 2'b11;
  assign aw_err    = fail_q | (|s_awaddr[31:MEM_ADDR_BITS]);
  assign ar_err    = fail_q | (|s_araddr[31:MEM_ADDR_BITS]);
  assign b_hs      = m_bvalid & m_bready;
  assign r_last_hs = m_rvalid & m_rready & m_rlast;

  // A completing response frees its slot in the same cycle, so a full counter does not cost a bubble.
  assign aw_fwd_ok = ready_q & ~aw_err & (ws_q == W_IDLE) & ((wcnt_q < CW'(MAX_OUTSTANDING)) | b_hs);
  assign ar_fwd_ok = ready_q & ~ar_err & (rs_q == R_IDLE) & ((rcnt_q < CW'(MAX_OUTSTANDING)) | r_last_hs);
  // Error bursts wait for the forwarded traffic to drain so no W beats are still owed to the controller.
  assign aw_err_ok = en & aw_err & (ws_q == W_IDLE) & (wcnt_q == '0);
  assign ar_err_ok = en & ar_err & (rs_q == R_IDLE) & (rcnt_q == '0);
  assign aw_fwd_hs = s_awvalid & aw_fwd_ok & m_awready;
  assign ar_fwd_hs = s_arvalid & ar_fwd_ok & m_arready;

  assign m_awid    = s_awid;
  assign m_awaddr  = s_awaddr;
  assign m_awlen   = s_awlen;
  assign m_awsize  = s_awsize;
  assign m_awburst = s_awburst;
  assign m_awvalid = s_awvalid & aw_fwd_ok;
  assign s_awready = (m_awready & aw_fwd_ok) | aw_err_ok;

  assign m_arid    = s_arid;
  assign m_araddr  = s_araddr;
  assign m_arlen   = s_arlen;
  assign m_arsize  = s_arsize;
  assign m_arburst = s_arburst;
  assign m_arvalid = s_arvalid & ar_fwd_ok;
  assign s_arready = (m_arready & ar_fwd_ok) | ar_err_ok;

  // W beats riding along with an error AW being accepted this cycle must not leak to the controller.
  assign w_pass   = (ws_q == W_IDLE) & ready_q & ~fail_q & ~(s_awvalid & aw_err_ok);
  assign m_wdata  = s_wdata;
  assign m_wstrb  = s_wstrb;
  assign m_wlast  = s_wlast;
  assign m_wvalid = s_wvalid & w_pass;
  assign s_wready = (ws_q == W_SINK) | (m_wready & w_pass);

  assign s_bvalid = (ws_q == W_RESP) | (ready_q & m_bvalid);
  assign s_bid    = (ws_q == W_RESP) ? wid_q : m_bid;
  assign s_bresp  = (ws_q == W_RESP) ? err_resp : m_bresp;
  assign m_bready = ready_q & (ws_q != W_RESP) & s_bready;

  assign s_rvalid = (rs_q == R_RESP) | (ready_q & m_rvalid);
  assign s_rid    = (rs_q == R_RESP) ? rid_q : m_rid;
  assign s_rdata  = (rs_q == R_RESP) ? '0 : m_rdata;
  assign s_rresp  = (rs_q == R_RESP) ? err_resp : m_rresp;
  assign s_rlast  = (rs_q == R_RESP) ? (beats_q == 8'd0) : m_rlast;
  assign m_rready = ready_q & (rs_q == R_IDLE) & s_rready;

  assign o_err_wr = err_wr_q;
  assign o_err_rd = err_rd_q;

  always_comb begin
    ready_d  = ready_q | i_init_done;
    fail_d   = fail_q | i_init_error;
    wcnt_d   = wcnt_q;
    rcnt_d   = rcnt_q;
    ws_d     = ws_q;
    rs_d     = rs_q;
    wid_d    = wid_q;
    rid_d    = rid_q;
    beats_d  = beats_q;
    err_wr_d = 1'b0;
    err_rd_d = 1'b0;

    if (aw_fwd_hs && !b_hs)      wcnt_d = wcnt_q + CW'(1);
    else if (!aw_fwd_hs && b_hs) wcnt_d = wcnt_q - CW'(1);
    if (ar_fwd_hs && !r_last_hs)      rcnt_d = rcnt_q + CW'(1);
    else if (!ar_fwd_hs && r_last_hs) rcnt_d = rcnt_q - CW'(1);

    case (ws_q)
      W_IDLE: if (s_awvalid && aw_err_ok) begin
        ws_d  = W_SINK;
        wid_d = s_awid;
      end
      W_SINK: if (s_wvalid && s_wlast) ws_d = W_RESP;
      W_RESP: if (s_bready) begin
        ws_d     = W_IDLE;
        err_wr_d = 1'b1;
      end
      default: ws_d = W_IDLE;
    endcase

    case (rs_q)
      R_IDLE: if (s_arvalid && ar_err_ok) begin
        rs_d    = R_RESP;
        rid_d   = s_arid;
        beats_d = s_arlen;
      end
      R_RESP: if (s_rready) begin
        if (beats_q == 8'd0) begin
          rs_d     = R_IDLE;
          err_rd_d = 1'b1;
        end else begin
          beats_d = beats_q - 8'd1;
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_q  <= 1'b0;
      fail_q   <= 1'b0;
      ws_q     <= W_IDLE;
      rs_q     <= R_IDLE;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      wid_q    <= '0;
      rid_q    <= '0;
      beats_q  <= '0;
      err_wr_q <= 1'b0;
      err_rd_q <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      fail_q   <= fail_d;
      ws_q     <= ws_d;
      rs_q     <= rs_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      wid_q    <= wid_d;
      rid_q    <= rid_d;
      beats_q  <= beats_d;
      err_wr_q <= err_wr_d;
      err_rd_q <= err_rd_d;
    end
  end
endmodule
